// File: rtl/lcd_pattern_seq_if.sv
// -----------------------------------------------------------------------------
// lcd_pattern_seq_if
//   Bundles the timing-generator input, the pattern controls and the
//   panel-side output of lcd_pattern_seq.
//   slave  : the pattern sequencer (consumes in_*, auto_en, next_req;
//            produces out_*, pattern, frame_start)
//   master : whatever drives the timing/control side and watches the panel
// -----------------------------------------------------------------------------
interface lcd_pattern_seq_if;
    logic       auto_en;      // 1 = advance pattern every HOLD_FRAMES frames
    logic       next_req;     // one-cycle advance request, clk-synchronous
    logic [9:0] in_x;         // active pixel x
    logic [9:0] in_y;         // active pixel y
    logic       in_hs;
    logic       in_vs;
    logic       in_de;
    logic       out_hs;       // in_hs delayed 1 cycle
    logic       out_vs;       // in_vs delayed 1 cycle
    logic       out_de;       // in_de delayed 1 cycle
    logic [4:0] out_r;
    logic [5:0] out_g;
    logic [4:0] out_b;
    logic [1:0] pattern;      // currently selected pattern
    logic       frame_start;  // pulse aligned with out_vs going active

    modport slave (
        input  auto_en, next_req, in_x, in_y, in_hs, in_vs, in_de,
        output out_hs, out_vs, out_de, out_r, out_g, out_b, pattern, frame_start
    );

    modport master (
        output auto_en, next_req, in_x, in_y, in_hs, in_vs, in_de,
        input  out_hs, out_vs, out_de, out_r, out_g, out_b, pattern, frame_start
    );
endinterface

// File: rtl/lcd_pattern_seq.sv
// -----------------------------------------------------------------------------
// lcd_pattern_seq
//   Test-pattern scheduler for the 480x272 RGB565 LCD path. Delays the raw
//   timing by one cycle and replaces the pixel data with one of four test
//   patterns. The pattern only changes at a frame start (vsync active edge),
//   either automatically every HOLD_FRAMES frames or on a next_req pulse.
//
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous active-low reset
//     lcd    lcd_pattern_seq_if.slave (timing in, controls, RGB565 out,
//            pattern, frame_start)
// -----------------------------------------------------------------------------
module lcd_pattern_seq #(
    parameter int   H_ACTIVE    = 480,
    parameter int   V_ACTIVE    = 272,
    parameter int   HOLD_FRAMES = 120,
    parameter logic VS_POL      = 1'b0,
    parameter logic HS_POL      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    lcd_pattern_seq_if.slave lcd
);

    localparam int         BAR_W     = H_ACTIVE / 16;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        PAT_COLORBAR = 2'd0,
        PAT_GRID     = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_CHECKER  = 2'd3
    } pat_e;

    pat_e        pat_q;
    logic [7:0]  hold_cnt;
    logic [7:0]  anim;
    logic        pend;

    logic        hs_q, vs_q, de_q, fs_q;
    logic [15:0] rgb_q;

    logic        fs_det;
    logic        advance;
    logic [9:0]  bar_div;
    logic [3:0]  bar_idx;
    logic [15:0] pix_c;

    // out_vs doubles as the vsync edge register; it resets inactive so a
    // reset never fabricates a frame start on its own.
    assign fs_det  = (lcd.in_vs == VS_POL) && (vs_q != VS_POL);

    // A request landing in the frame-start cycle itself counts immediately.
    assign advance = pend | lcd.next_req | (lcd.auto_en & (hold_cnt == HOLD_LAST));

    // Colour-bar index, clamped so the leftover columns past 16*BAR_W stay
    // in the last bar.
    always_comb begin
        bar_div = lcd.in_x / 10'(BAR_W);
        bar_idx = (bar_div > 10'd15) ? 4'd15 : bar_div[3:0];
    end

    // Pixel generation uses the pattern in force this cycle; a pattern
    // switch lands on the same edge that registers frame_start, i.e. inside
    // vertical blanking.
    always_comb begin
        pix_c = 16'h0000;
        case (pat_q)
            PAT_COLORBAR: pix_c = 16'h8000 >> bar_idx;
            PAT_GRID: begin
                if (lcd.in_x[4:0] == 5'd0 || lcd.in_y[4:0] == 5'd0 ||
                    lcd.in_x == X_LAST     || lcd.in_y == Y_LAST)
                    pix_c = 16'hFFFF;
            end
            PAT_GRADIENT: pix_c = {lcd.in_x[8:4], lcd.in_y[8:3], anim[4:0]};
            PAT_CHECKER: begin
                if (lcd.in_x[5] ^ lcd.in_y[5] ^ anim[5])
                    pix_c = 16'hFFFF;
            end
            default: pix_c = 16'h0000;
        endcase
        if (!lcd.in_de)
            pix_c = 16'h0000;
    end

    // Video path: everything delayed exactly one cycle so sync, DE and RGB
    // stay aligned at the panel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            rgb_q <= 16'h0000;
        end else begin
            hs_q  <= lcd.in_hs;
            vs_q  <= lcd.in_vs;
            de_q  <= lcd.in_de;
            fs_q  <= fs_det;
            rgb_q <= pix_c;
        end
    end

    // Pattern scheduling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= PAT_COLORBAR;
            hold_cnt <= 8'd0;
            anim     <= 8'd0;
            pend     <= 1'b0;
        end else if (fs_det) begin
            anim <= anim + 8'd1;
            if (advance) begin
                pat_q    <= pat_e'(pat_q + 2'd1);
                hold_cnt <= 8'd0;
                pend     <= 1'b0;
            end else if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end else if (lcd.next_req) begin
            // Single bit: any number of requests in a frame -> one advance.
            pend <= 1'b1;
        end
    end

    assign lcd.out_hs      = hs_q;
    assign lcd.out_vs      = vs_q;
    assign lcd.out_de      = de_q;
    assign lcd.out_r       = rgb_q[15:11];
    assign lcd.out_g       = rgb_q[10:5];
    assign lcd.out_b       = rgb_q[4:0];
    assign lcd.pattern     = pat_q;
    assign lcd.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_pattern_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_pattern_seq
//   Self-checking bench for lcd_pattern_seq. Frames are shortened: a frame is
//   a vsync pulse followed by a handful of (often random) active pixels, which
//   the block cannot tell apart from a full 480x272 raster.
// -----------------------------------------------------------------------------
module tb_lcd_pattern_seq;

    localparam int   HOLD   = 3;
    localparam logic VS_POL = 1'b0;
    localparam logic HS_POL = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    lcd_pattern_seq_if lcd();

    lcd_pattern_seq #(
        .H_ACTIVE(480), .V_ACTIVE(272), .HOLD_FRAMES(HOLD),
        .VS_POL(VS_POL), .HS_POL(HS_POL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lcd  (lcd.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] rgb_o;
    assign rgb_o = {lcd.out_r, lcd.out_g, lcd.out_b};

    // ---------------- reference model (frame-level behaviour) ----------------
    int          m_pat, m_hold, m_anim;
    bit          m_pend, m_prev_vs;
    logic [15:0] e_rgb;
    bit          e_hs, e_vs, e_de, e_fs;

    function automatic logic [15:0] pix(input int pat, input int anim,
                                        input int x, input int y, input bit de);
        int bar;
        if (!de) return 16'h0000;
        case (pat)
            0: begin
                bar = 0;
                for (int b = 1; b < 16; b++) if (x >= b * 30) bar = b;
                return 16'h8000 >> bar;
            end
            1: return ((x % 32) == 0 || (y % 32) == 0 || x == 479 || y == 271)
                      ? 16'hFFFF : 16'h0000;
            2: return {5'((x / 16) % 32), 6'((y / 8) % 64), 5'(anim % 32)};
            default: return ((((x / 32) + (y / 32) + (anim / 32)) % 2) == 1)
                      ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pat = 0; m_hold = 0; m_anim = 0; m_pend = 0; m_prev_vs = !VS_POL;
    endtask

    // Drive one pixel cycle, predict the registered result, advance one edge.
    task automatic step(input int x, input int y, input bit hs, input bit vs,
                        input bit de, input bit req);
        lcd.in_x = 10'(x); lcd.in_y = 10'(y);
        lcd.in_hs = hs; lcd.in_vs = vs; lcd.in_de = de; lcd.next_req = req;
        e_rgb = pix(m_pat, m_anim, x, y, de);
        e_hs = hs; e_vs = vs; e_de = de;
        e_fs = (vs == VS_POL) && (m_prev_vs != VS_POL);
        if (e_fs) begin
            m_anim = (m_anim + 1) % 256;
            if (m_pend || req || (lcd.auto_en && m_hold == HOLD - 1)) begin
                m_pat = (m_pat + 1) % 4; m_hold = 0; m_pend = 0;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end else if (req) begin
            m_pend = 1;
        end
        m_prev_vs = vs;
        @(posedge clk); #1;
    endtask

    // vsync pulse of 2 cycles then inactive; records frame_start/out_vs per cycle.
    task automatic vs_pulse(input bit req_edge, input bit req_after,
                            output bit [2:0] fs_vec, output bit [2:0] vs_vec);
        step(0, 0, !HS_POL, VS_POL, 0, req_edge);
        fs_vec[0] = lcd.frame_start; vs_vec[0] = lcd.out_vs;
        step(0, 0, !HS_POL, VS_POL, 0, req_after);
        fs_vec[1] = lcd.frame_start; vs_vec[1] = lcd.out_vs;
        step(0, 0, !HS_POL, !VS_POL, 0, 0);
        fs_vec[2] = lcd.frame_start; vs_vec[2] = lcd.out_vs;
    endtask

    task automatic idle_inputs();
        lcd.in_x = '0; lcd.in_y = '0; lcd.in_hs = !HS_POL; lcd.in_vs = !VS_POL;
        lcd.in_de = 1'b0; lcd.next_req = 1'b0;
    endtask

    // Called at posedge+1; releases between edges and resyncs to posedge+1.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++; if (lcd.out_hs !== !HS_POL) begin n_err++; $display("FAIL reset_hs got %b exp %b", lcd.out_hs, !HS_POL); end
        n_vec++; if (lcd.out_vs !== !VS_POL) begin n_err++; $display("FAIL reset_vs got %b exp %b", lcd.out_vs, !VS_POL); end
        n_vec++; if (lcd.out_de !== 1'b0) begin n_err++; $display("FAIL reset_de got %b exp 0", lcd.out_de); end
        n_vec++; if (rgb_o !== 16'h0000) begin n_err++; $display("FAIL reset_rgb got %h exp 0000", rgb_o); end
        n_vec++; if (lcd.pattern !== 2'd0) begin n_err++; $display("FAIL reset_pattern got %0d exp 0", lcd.pattern); end
        n_vec++; if (lcd.frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b exp 0", lcd.frame_start); end
    endtask

    task automatic test_colorbar();
        int xs[4] = '{0, 29, 30, 479};
        logic [15:0] ws[4] = '{16'h8000, 16'h8000, 16'h4000, 16'h0001};
        bit [2:0] fv, vv;
        int x, y; bit de;
        lcd.auto_en = 1'b0;
        do_reset();
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (fv !== 3'b001) begin n_err++; $display("FAIL cb_fs got %b exp 001", fv); end
        n_vec++; if (lcd.pattern !== 2'd0) begin n_err++; $display("FAIL cb_pattern got %0d exp 0", lcd.pattern); end
        for (int i = 0; i < 4; i++) begin
            step(xs[i], 7, !HS_POL, !VS_POL, 1, 0);
            n_vec++; if (rgb_o !== ws[i]) begin n_err++; $display("FAIL cb_x%0d got %h exp %h", xs[i], rgb_o, ws[i]); end
        end
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, 479); y = $urandom_range(0, 271); de = 1'($urandom_range(0, 1));
            step(x, y, !HS_POL, !VS_POL, de, 0);
            n_vec++; if (rgb_o !== e_rgb || lcd.out_de !== e_de || (!lcd.out_de && rgb_o !== 16'h0000)) begin
                n_err++; $display("FAIL cb_rand x=%0d de=%b got %h/%b exp %h/%b", x, de, rgb_o, lcd.out_de, e_rgb, e_de);
            end
        end
    endtask

    task automatic test_auto();
        bit [2:0] fv, vv;
        int x, y;
        lcd.auto_en = 1'b1;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            vs_pulse(0, 0, fv, vv);
            n_vec++; if (fv !== 3'b001 || vv !== {!VS_POL, VS_POL, VS_POL}) begin
                n_err++; $display("FAIL auto_fs k=%0d fs %b vs %b", k, fv, vv);
            end
            n_vec++; if (lcd.pattern !== 2'((k / 3) % 4)) begin
                n_err++; $display("FAIL auto_pattern k=%0d got %0d exp %0d", k, lcd.pattern, (k / 3) % 4);
            end
            for (int i = 0; i < 4; i++) begin
                x = $urandom_range(0, 479); y = $urandom_range(0, 271);
                step(x, y, !HS_POL, !VS_POL, 1, 0);
                n_vec++; if (rgb_o !== e_rgb) begin n_err++; $display("FAIL auto_pix got %h exp %h", rgb_o, e_rgb); end
            end
        end
        lcd.auto_en = 1'b0;
    endtask

    task automatic test_next_req();
        bit [2:0] fv, vv;
        lcd.auto_en = 1'b0;
        do_reset();
        vs_pulse(0, 0, fv, vv);
        for (int i = 0; i < 3; i++) begin
            step(10 * i, 5, !HS_POL, !VS_POL, 1, 1);
            step(10 * i + 1, 5, !HS_POL, !VS_POL, 1, 0);
            n_vec++; if (lcd.pattern !== 2'd0) begin n_err++; $display("FAIL req_early got %0d exp 0", lcd.pattern); end
        end
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd1) begin n_err++; $display("FAIL req_adv got %0d exp 1", lcd.pattern); end
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd1) begin n_err++; $display("FAIL req_once got %0d exp 1", lcd.pattern); end
    endtask

    task automatic test_req_on_edge();
        bit [2:0] fv, vv;
        vs_pulse(1, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd2) begin n_err++; $display("FAIL edge_adv got %0d exp 2", lcd.pattern); end
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd2) begin n_err++; $display("FAIL edge_pend got %0d exp 2", lcd.pattern); end
    endtask

    task automatic test_req_after_fs();
        bit [2:0] fv, vv;
        vs_pulse(0, 1, fv, vv);
        step(100, 100, !HS_POL, !VS_POL, 1, 0);
        n_vec++; if (lcd.pattern !== 2'd2) begin n_err++; $display("FAIL after_hold got %0d exp 2", lcd.pattern); end
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd3) begin n_err++; $display("FAIL after_adv got %0d exp 3", lcd.pattern); end
    endtask

    task automatic test_grid();
        bit [2:0] fv, vv;
        int px[3] = '{32, 33, 479};
        int py[3] = '{5, 5, 100};
        logic [15:0] pw[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        int x, y;
        do_reset();
        vs_pulse(1, 0, fv, vv);
        n_vec++; if (lcd.pattern !== 2'd1) begin n_err++; $display("FAIL grid_sel got %0d exp 1", lcd.pattern); end
        for (int i = 0; i < 3; i++) begin
            step(px[i], py[i], !HS_POL, !VS_POL, 1, 0);
            n_vec++; if (rgb_o !== pw[i]) begin n_err++; $display("FAIL grid_%0d_%0d got %h exp %h", px[i], py[i], rgb_o, pw[i]); end
        end
        for (int i = 0; i < 20; i++) begin
            x = ($urandom_range(0, 1) != 0) ? 32 * $urandom_range(0, 14) : $urandom_range(0, 479);
            y = $urandom_range(0, 271);
            step(x, y, !HS_POL, !VS_POL, 1, 0);
            n_vec++; if (rgb_o !== e_rgb) begin n_err++; $display("FAIL grid_rand (%0d,%0d) got %h exp %h", x, y, rgb_o, e_rgb); end
        end
    endtask

    task automatic test_checker();
        bit [2:0] fv, vv;
        do_reset();
        for (int i = 0; i < 3; i++) vs_pulse(1, 0, fv, vv);
        step(0, 0, !HS_POL, !VS_POL, 1, 0);
        n_vec++; if (lcd.pattern !== 2'd3 || rgb_o !== 16'h0000) begin
            n_err++; $display("FAIL chk_lo pattern %0d rgb %h exp 3/0000", lcd.pattern, rgb_o);
        end
        for (int i = 0; i < 32; i++) vs_pulse(0, 0, fv, vv);
        step(0, 0, !HS_POL, !VS_POL, 1, 0);
        n_vec++; if (lcd.pattern !== 2'd3 || rgb_o !== 16'hFFFF) begin
            n_err++; $display("FAIL chk_hi pattern %0d rgb %h exp 3/ffff", lcd.pattern, rgb_o);
        end
    endtask

    task automatic test_reset_mid();
        bit [2:0] fv, vv;
        do_reset();
        vs_pulse(1, 0, fv, vv);
        vs_pulse(1, 0, fv, vv);
        step(100, 100, !HS_POL, !VS_POL, 1, 0);
        step(101, 100, !HS_POL, !VS_POL, 1, 0);
        n_vec++; if (lcd.pattern !== 2'd2 || rgb_o === 16'h0000) begin
            n_err++; $display("FAIL mid_pre pattern %0d rgb %h exp 2/nonzero", lcd.pattern, rgb_o);
        end
        // asynchronous: checked between clock edges
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (lcd.pattern !== 2'd0 || rgb_o !== 16'h0000 || lcd.out_de !== 1'b0 ||
                     lcd.out_vs !== !VS_POL || lcd.out_hs !== !HS_POL || lcd.frame_start !== 1'b0) begin
            n_err++; $display("FAIL mid_async pat %0d rgb %h de %b vs %b hs %b fs %b",
                              lcd.pattern, rgb_o, lcd.out_de, lcd.out_vs, lcd.out_hs, lcd.frame_start);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            step(102 + i, 100, !HS_POL, !VS_POL, 1, 0);
            n_vec++; if (lcd.frame_start !== 1'b0 || rgb_o !== e_rgb) begin
                n_err++; $display("FAIL mid_line fs %b rgb %h exp 0/%h", lcd.frame_start, rgb_o, e_rgb);
            end
        end
        vs_pulse(0, 0, fv, vv);
        n_vec++; if (fv !== 3'b001 || lcd.pattern !== 2'd0) begin
            n_err++; $display("FAIL mid_first fs %b pattern %0d exp 001/0", fv, lcd.pattern);
        end
    endtask

    task automatic test_random();
        bit [2:0] fv, vv;
        int x, y; bit hs, de, rq;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            lcd.auto_en = 1'($urandom_range(0, 1));
            vs_pulse($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, fv, vv);
            n_vec++; if (fv !== 3'b001 || lcd.pattern !== 2'(m_pat)) begin
                n_err++; $display("FAIL rnd_frame f=%0d fs %b pattern %0d exp 001/%0d", f, fv, lcd.pattern, m_pat);
            end
            for (int i = 0; i < 20; i++) begin
                x = $urandom_range(0, 479); y = $urandom_range(0, 271);
                hs = 1'($urandom_range(0, 1)); de = 1'($urandom_range(0, 1));
                rq = ($urandom_range(0, 15) == 0);
                step(x, y, hs, !VS_POL, de, rq);
                n_vec++; if (rgb_o !== e_rgb || lcd.out_de !== e_de || lcd.out_hs !== e_hs ||
                             lcd.out_vs !== e_vs || lcd.frame_start !== e_fs || lcd.pattern !== 2'(m_pat)) begin
                    n_err++; $display("FAIL rnd_pix (%0d,%0d) rgb %h/%h de %b/%b hs %b/%b vs %b/%b fs %b/%b pat %0d/%0d",
                                      x, y, rgb_o, e_rgb, lcd.out_de, e_de, lcd.out_hs, e_hs,
                                      lcd.out_vs, e_vs, lcd.frame_start, e_fs, lcd.pattern, m_pat);
                end
            end
        end
        lcd.auto_en = 1'b0;
    endtask

    initial begin
        idle_inputs();
        lcd.auto_en = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #5;
        test_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        test_colorbar();
        test_auto();
        test_next_req();
        test_req_on_edge();
        test_req_after_fs();
        test_grid();
        test_checker();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_seq.md
# lcd_pattern_seq

Test-pattern scheduler for the 480x272 RGB565 LCD path. Sits between `vga_timing` and the panel pins. It takes the raw timing (`hs`/`vs`/`de`, `active_x`/`active_y`) and decides which of four test patterns is drawn each frame. Pattern changes happen only on frame boundaries, either automatically every `HOLD_FRAMES` frames or on an external request. The block outputs registered, timing-aligned RGB565 pixels.

## Interface
- `H_ACTIVE`, 480, active pixels per line
- `V_ACTIVE`, 272, active lines per frame
- `HOLD_FRAMES`, 120, frames per pattern in auto mode (1..255)
- `VS_POL`, 0, active level of `in_vs`/`out_vs`
- `HS_POL`, 0, active level of `in_hs`/`out_hs`

- `clk`  in  1  pixel clock (`lcd_dclk` domain)
- `rst_n`  in  1  reset, asynchronous, active-low
- `auto_en`  in  1  1 = advance pattern every `HOLD_FRAMES` frames
- `next_req`  in  1  single-cycle pulse, already synchronous to `clk`; request advance to next pattern
- `in_x`  in  10  active pixel x from timing generator
- `in_y`  in  10  active pixel y from timing generator
- `in_hs`  in  1  horizontal sync from timing generator
- `in_vs`  in  1  vertical sync from timing generator
- `in_de`  in  1  data enable from timing generator
- `out_hs`  out  1  `in_hs` delayed 1 cycle
- `out_vs`  out  1  `in_vs` delayed 1 cycle
- `out_de`  out  1  `in_de` delayed 1 cycle
- `out_r`  out  5  red
- `out_g`  out  6  green
- `out_b`  out  5  blue
- `pattern`  out  2  currently selected pattern
- `frame_start`  out  1  one-cycle pulse aligned with `out_vs` going active

## Operation
- Frame start: detected when `in_vs` is at `VS_POL` and the previous-cycle `in_vs` was `!VS_POL`. The edge register resets to `!VS_POL`, so no spurious frame start is seen after reset.
- `pend`: set by `next_req`, cleared at frame start. It holds one bit only, so multiple requests within a frame produce one advance.
- `hold_cnt` (8b): counts frames shown in the current pattern.
- Decision at each frame start:
  - Advance if `pend`, or if `next_req` is high in this same cycle.
  - Otherwise advance if `auto_en` and `hold_cnt == HOLD_FRAMES-1`.
  - Otherwise do not advance.
- On advance: `pattern <= pattern+1` (wraps 3 -> 0), `hold_cnt <= 0`, `pend <= 0`.
- On no advance: `hold_cnt <= hold_cnt+1`, saturating at 255. `pend <= 0` applies only on advance; a no-advance frame start leaves `pend` unchanged, and `pend` is 0 in that case anyway.
- Clearing `auto_en` freezes auto advance; `hold_cnt` keeps counting.
- `anim` (8b): free-running frame counter, increments every frame start and wraps 255 -> 0. It is independent of pattern changes.
- Patterns, computed from the current-cycle `in_x`/`in_y`, `pattern` and `anim`:
  - 0 COLORBAR: `BAR_W = H_ACTIVE/16` (integer). Bar index `i = min(in_x / BAR_W, 15)`. RGB565 word = `16'h8000 >> i`, i.e. a walking one from r[4] down to b[0].
  - 1 GRID: 16'hFFFF if `in_x[4:0]==0`, `in_y[4:0]==0`, `in_x==H_ACTIVE-1` or `in_y==V_ACTIVE-1`; otherwise 16'h0000.
  - 2 GRADIENT: r = `in_x[8:4]`, g = `in_y[8:3]`, b = `anim[4:0]`.
  - 3 CHECKER: 16'hFFFF if `in_x[5]^in_y[5]^anim[5]`, else 16'h0000.
- RGB output is registered. If `in_de` is 0, the registered RGB is 16'h0000.
- Pattern selection uses the `pattern` value present in the same cycle as the pixel.

## Timing
- Latency: 1 cycle, from `in_*` to `out_*`/RGB. `out_hs`, `out_vs`, `out_de` and RGB stay mutually aligned.
- `frame_start` is registered and asserts in the same cycle `out_vs` first shows `VS_POL`.
- `pattern` updates on the clock edge that registers `frame_start`. Active video follows vsync, so every active pixel of a frame uses one pattern and no tearing occurs.
- Reset values:
  - `out_hs = !HS_POL`, `out_vs = !VS_POL`, `out_de = 0`
  - RGB = 0, `pattern = 0`, `frame_start = 0`
  - `hold_cnt = 0`, `anim = 0`, `pend = 0`
- Reset asserted mid-frame: all state clears immediately. The first frame start after release is detected normally and only counts; pattern 0 is kept unless a request is pending.
- `next_req` arriving in the cycle after a frame start is held in `pend` until the next frame start.

## Test plan
- Reset, then stream a 480x272 frame with `auto_en=0` -> `pattern=0`. Pixel x=0 gives RGB 16'h8000, x=29 gives 16'h8000, x=30 gives 16'h4000, x=479 gives 16'h0001. `out_de` lags `in_de` by exactly 1 cycle; RGB is 0 whenever `out_de=0`.
- `auto_en=1`, `HOLD_FRAMES=3`, run 13 frames -> `pattern` steps 0,1,2,3,0 every 3 frame starts. `frame_start` pulses exactly once per frame, aligned with `out_vs`.
- `auto_en=0`, pulse `next_req` 3 times mid-frame -> exactly one advance, taking effect at the next frame start. Pattern is unchanged before that frame start.
- `next_req` in the same cycle as the vs active edge -> advance occurs at that frame start; `pend` is 0 afterwards.
- Pattern 1: pixel (32,5) = 16'hFFFF, (33,5) = 16'h0000, (479,100) = 16'hFFFF. Pattern 3: (0,0) = 16'h0000 when `anim=0`, and 16'hFFFF after 32 frames.
- Assert `rst_n` low mid-line with `pattern=2` -> all outputs go to their reset values asynchronously. After release, the first frame shows pattern 0 and no extra `frame_start` pulse occurs.
